mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
Sequences the shared MAC datapath (8x8 registered multiplier feeding a 16-bit accumulator) to compute one dot product per command. It accepts a start command with a vector length, streams operand pairs in over a valid/ready handshake, and aligns the accumulate-enable with the multiplier latency. When the last product has been accumulated, it returns the sum over a valid/ready result port. It sits between the operand-fetch logic and the MAC instance and is the only driver of the MAC's reset, enable and operand inputs.

Parameters:
DW, 8, operand width (matches MAC B/C)
AW, 16, accumulator/result width (matches MAC A)
LEN_W, 8, width of vector-length field
MUL_LAT, 1, multiplier latency in cycles from MAC operand input to product valid (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  command strobe, sampled only in IDLE
len  input  LEN_W  number of operand pairs, latched with start
busy  output  1  high whenever state != IDLE
op_valid  input  1  operand pair valid
op_ready  output  1  sequencer accepts operand pair
op_b  input  DW  operand B
op_c  input  DW  operand C
res_valid  output  1  result valid
res_ready  input  1  result consumed
res_data  output  AW  dot-product result
mac_clr  output  1  to MAC rst; clears accumulator
mac_en  output  1  to MAC en
mac_b  output  DW  to MAC B
mac_c  output  DW  to MAC C
mac_acc  input  AW  from MAC A

Behaviour:
- Reset values: state=IDLE, busy=0, op_ready=0, res_valid=0, res_data=0, mac_en=0, mac_b=0, mac_c=0, beat count=0, enable pipeline=0.
- mac_clr = rst OR (state==CLEAR). The MAC is therefore cleared during reset.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR on start. len is latched. start is ignored in every other state.
- CLEAR: lasts exactly 1 cycle with mac_clr=1.
  - Next state is FEED if the latched len != 0.
  - If len == 0, next state is DONE with res_data=0.
- FEED: op_ready=1.
  - A transfer occurs on op_valid & op_ready. At that edge, mac_b/mac_c are registered from op_b/op_c and a 1 is shifted into the enable pipeline.
  - Pipeline depth is MUL_LAT; its output drives mac_en.
  - Net timing: for a transfer at edge k, mac_en is high in cycle k+MUL_LAT, and the accumulator updates at the end of that cycle.
  - mac_b/mac_c hold their value between transfers.
  - Bubbles (op_valid=0) shift 0 into the pipeline; no accumulation occurs.
  - Once the len-th transfer is accepted, op_ready drops in the following cycle and state goes to DRAIN.
- DRAIN: op_ready=0.
  - Exit condition: enable pipeline all zero AND mac_en low in the current cycle, so the final update is visible on mac_acc.
  - On exit, res_data <= mac_acc and state goes to DONE.
  - Fixed latency: last transfer at edge k gives res_valid high from cycle k+MUL_LAT+2.
- DONE: res_valid=1, with res_data stable until res_ready.
  - On res_valid & res_ready, state goes to IDLE and res_valid goes to 0 at the next edge.
  - The MAC is not cleared in DONE; clearing happens only in CLEAR of the next command.
- Arithmetic: products are unsigned DW x DW. Accumulation wraps modulo 2^AW. No saturation, no overflow flag.
- Back-to-back: op_valid held high in FEED gives one transfer per cycle, i.e. full throughput.
- Reset mid-operation (any state): IDLE on the next edge.
  - All outputs return to reset values.
  - Pipeline contents are flushed.
  - The accumulator is cleared through mac_clr.
  - No partial result is emitted.
- start and res_ready asserted together in DONE: res_ready is honoured and start is ignored.
- Exactly one result is produced per accepted start.

Test Plan:
- MUL_LAT=1, len=4, B={1,2,3,4}, C={5,6,7,8}, op_valid held high -> 4 transfers on consecutive cycles; res_data=0x0046; res_valid high 3 cycles after the 4th transfer edge.
- Same vectors with op_valid low for 2 cycles between each pair -> res_data=0x0046; mac_en pulse count=4; op_ready never high outside FEED.
- len=2, B=C={255,255} -> res_data=0xFC02 (wrap of 130050).
- len=0 -> CLEAR then DONE; res_data=0x0000; op_ready never asserted.
- res_ready low 5 cycles after res_valid, with start pulsed meanwhile -> res_data stable; start ignored; after the handshake, busy=0; a second command (len=1, B=3, C=3) gives 0x0009, with no carry-over from the first sum.
- rst asserted in FEED after 2 of 4 transfers -> IDLE next cycle; mac_clr high during rst; mac_en=0; no res_valid; a subsequent len=1, B=2, C=2 gives 0x0004.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer for the shared 8x8 MAC.
// It streams operand pairs into the MAC and returns the accumulated sum.
module mac_dot_sequencer #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_b,
  input  logic [DW-1:0]    op_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_data,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [DW-1:0]    mac_b,
  output logic [DW-1:0]    mac_c,
  input  logic [AW-1:0]    mac_acc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      res_q, res_d;
  logic [DW-1:0]      b_q, b_d;
  logic [DW-1:0]      c_q, c_d;
  logic [MUL_LAT-1:0] pipe_q, pipe_d;
  logic               en_q;
  logic               xfer;
  logic               last;
  logic               drained;

  assign xfer    = (state_q == S_FEED) && op_valid;
  assign last    = (cnt_q == len_q - LEN_W'(1));
  // mac_en is one register past the pipeline tail, so the final
  // update has landed on mac_acc once both are quiet.
  assign drained = (pipe_q == '0) && !en_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    b_d     = b_q;
    c_d     = c_q;
    pipe_d  = MUL_LAT'({pipe_q, xfer});
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        if (len_q == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (op_valid) begin
          b_d   = op_b;
          c_d   = op_c;
          cnt_d = cnt_q + LEN_W'(1);
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          res_d   = mac_acc;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      pipe_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      b_q     <= b_d;
      c_q     <= c_d;
      pipe_q  <= pipe_d;
      en_q    <= pipe_q[MUL_LAT-1];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign op_ready  = (state_q == S_FEED);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;
  assign mac_clr   = rst || (state_q == S_CLEAR);
  assign mac_en    = en_q;
  assign mac_b     = b_q;
  assign mac_c     = c_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized bench for mac_dot_sequencer with a behavioural MAC
// and a plain-arithmetic dot-product reference.
module tb_mac_dot_sequencer;

  localparam int DW      = 8;
  localparam int AW      = 16;
  localparam int LEN_W   = 8;
  localparam int MUL_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [DW-1:0]    op_b = '0;
  logic [DW-1:0]    op_c = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [AW-1:0]    res_data;
  logic             mac_clr;
  logic             mac_en;
  logic [DW-1:0]    mac_b;
  logic [DW-1:0]    mac_c;
  logic [AW-1:0]    mac_acc = '0;

  mac_dot_sequencer #(
    .DW(DW), .AW(AW), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
    .op_b(op_b), .op_c(op_c), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_b(mac_b), .mac_c(mac_c), .mac_acc(mac_acc)
  );

  always #5 clk = ~clk;

  // Environment model of the MAC: registered product, then accumulate.
  logic [2*DW-1:0] prod_q [MUL_LAT];
  always @(posedge clk) begin
    prod_q[0] <= (2*DW)'(mac_b) * (2*DW)'(mac_c);
    for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
    if (mac_clr) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + AW'(prod_q[MUL_LAT-1]);
  end

  int cyc = 0;
  int en_pulses = 0;
  int rdy_cyc = 0;
  int rdy_bad = 0;
  int rv_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_en) en_pulses <= en_pulses + 1;
    if (op_ready) rdy_cyc <= rdy_cyc + 1;
    if (op_ready && !busy) rdy_bad <= rdy_bad + 1;
    if (res_valid) rv_cyc <= rv_cyc + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] vb [64];
  logic [DW-1:0] vc [64];

  task automatic run_cmd(input int n, input int gap,
                         input int rdly, input bit poke);
    int unsigned sum;
    int i, g, t, last, sedge, en0, rdy0;
    logic [AW-1:0] exp;
    sum = 0;
    for (int k = 0; k < n; k++) sum += int'(vb[k]) * int'(vc[k]);
    exp = AW'(sum % 65536);
    en0 = en_pulses;
    rdy0 = rdy_cyc;
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    sedge = cyc;
    chk("busy_on", 32'(busy), 1);
    chk("clr_on", 32'(mac_clr), 1);
    i = 0; g = 0; t = 0; last = 0;
    while (i < n && t < 1000) begin
      @(negedge clk);
      t++;
      if (g > 0) begin
        op_valid = 1'b0;
        g--;
      end else begin
        op_valid = 1'b1;
        op_b = vb[i];
        op_c = vc[i];
        if (op_ready) begin
          i++;
          last = cyc + 1;
          g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
        end
      end
    end
    chk("feed_to", 32'(i), 32'(n));
    if (n > 0) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
    t = 0;
    while (!res_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("res_to", 32'(res_valid), 1);
    if (n > 0) chk("lat", 32'(cyc), 32'(last + MUL_LAT + 2));
    else chk("lat0", 32'(cyc), 32'(sedge + 1));
    chk("res", 32'(res_data), 32'(exp));
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      start = poke && (k == 1);
    end
    chk("hold", 32'(res_data), 32'(exp));
    chk("hold_v", 32'(res_valid), 1);
    @(negedge clk);
    res_ready = 1'b1;
    start = poke;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk("rv_lo", 32'(res_valid), 0);
    chk("idle", 32'(busy), 0);
    chk("en_cnt", 32'(en_pulses - en0), 32'(n));
    if (n == 0) chk("rdy_len0", 32'(rdy_cyc - rdy0), 0);
  endtask

  task automatic reset_mid;
    int i, t, en0, rv0;
    for (int k = 0; k < 4; k++) begin
      vb[k] = DW'(k + 1);
      vc[k] = DW'(k + 5);
    end
    rv0 = rv_cyc;
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    i = 0; t = 0;
    while (i < 2 && t < 50) begin
      @(negedge clk);
      t++;
      op_valid = 1'b1;
      op_b = vb[i];
      op_c = vc[i];
      if (op_ready) i++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(op_ready), 0);
    chk("rst_en", 32'(mac_en), 0);
    chk("rst_clr", 32'(mac_clr), 1);
    chk("rst_rv", 32'(res_valid), 0);
    chk("rst_acc", 32'(mac_acc), 0);
    rst = 1'b0;
    en0 = en_pulses;
    repeat (6) @(negedge clk);
    chk("rst_flush", 32'(en_pulses - en0), 0);
    chk("rst_nores", 32'(rv_cyc - rv0), 0);
    chk("rst_idle", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("r_busy", 32'(busy), 0);
    chk("r_rdy", 32'(op_ready), 0);
    chk("r_rv", 32'(res_valid), 0);
    chk("r_data", 32'(res_data), 0);
    chk("r_en", 32'(mac_en), 0);
    chk("r_b", 32'(mac_b), 0);
    chk("r_c", 32'(mac_c), 0);
    chk("r_clr", 32'(mac_clr), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_idle", 32'(mac_clr), 0);

    for (int k = 0; k < 4; k++) begin
      vb[k] = DW'(k + 1);
      vc[k] = DW'(k + 5);
    end
    run_cmd(4, 0, 0, 1'b0);
    run_cmd(4, 2, 0, 1'b0);
    vb[0] = 8'hff; vc[0] = 8'hff;
    vb[1] = 8'hff; vc[1] = 8'hff;
    run_cmd(2, 0, 1, 1'b0);
    run_cmd(0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vb[k] = DW'(k + 1);
      vc[k] = DW'(k + 5);
    end
    run_cmd(4, 0, 5, 1'b1);
    vb[0] = 8'd3; vc[0] = 8'd3;
    run_cmd(1, 0, 0, 1'b0);

    reset_mid();
    vb[0] = 8'd2; vc[0] = 8'd2;
    run_cmd(1, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(12, 0));
      for (int k = 0; k < n; k++) begin
        vb[k] = DW'($urandom);
        vc[k] = DW'($urandom);
      end
      run_cmd(n, -1, int'($urandom_range(3, 0)), 1'($urandom));
    end

    chk("rdy_out", 32'(rdy_bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
